// File: rtl/trim_pkg.sv
// Shared constants and FSM state encoding for the bandgap trim SAR search.
package trim_pkg;

  localparam int unsigned TRIM_WIDTH     = 12;
  localparam int unsigned SETTLE_CYC_DEF = 1000;
  localparam int unsigned LD_TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_LD,
    SETTLE,
    SAMPLE,
    FINAL_LOAD,
    FINAL_WAIT
  } state_t;

endpackage

// File: rtl/trim_cmp_sync.sv
// Two-flop synchronizer bringing the asynchronous bandgap comparator into clk50.
module trim_cmp_sync (
  input  logic clk50,
  input  logic rst,
  input  logic cmp,
  output logic cmp_s
);

  logic [1:0] sync;

  always_ff @(posedge clk50) begin
    if (rst) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], cmp};
    end
  end

  assign cmp_s = sync[1];

endmodule

// File: rtl/trim_sar_ctrl.sv
// Successive-approximation trim search: loads candidate codes through the serial
// loader, samples the comparator after settling, and resolves one bit per pass.
module trim_sar_ctrl
  import trim_pkg::*;
#(
  parameter int unsigned WIDTH      = TRIM_WIDTH,
  parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int unsigned LD_TIMEOUT = LD_TIMEOUT_DEF
) (
  input  logic             clk50,
  input  logic             rst,
  input  logic             go,
  input  logic             cmp,
  input  logic             ld_done,
  output logic             ld_start,
  output logic [WIDTH-1:0] trimcode,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int unsigned TW = (LD_TIMEOUT > 1) ? $clog2(LD_TIMEOUT) : 1;

  localparam logic [IW-1:0] IDX_MSB     = IW'(WIDTH - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(LD_TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [IW-1:0]    idx, idx_nxt;
  logic [SW-1:0]    settle_cnt, settle_cnt_nxt;
  logic [TW-1:0]    to_cnt, to_cnt_nxt;
  logic [WIDTH-1:0] trimcode_nxt, result_nxt;
  logic             ld_start_nxt, busy_nxt, done_nxt, fail_nxt;
  logic             cmp_s;

  trim_cmp_sync u_cmp_sync (
    .clk50 (clk50),
    .rst   (rst),
    .cmp   (cmp),
    .cmp_s (cmp_s)
  );

  always_ff @(posedge clk50) begin
    if (rst) begin
      state      <= IDLE;
      trimcode   <= '0;
      idx        <= IDX_MSB;
      settle_cnt <= '0;
      to_cnt     <= '0;
      ld_start   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      result     <= '0;
    end else begin
      state      <= state_nxt;
      trimcode   <= trimcode_nxt;
      idx        <= idx_nxt;
      settle_cnt <= settle_cnt_nxt;
      to_cnt     <= to_cnt_nxt;
      ld_start   <= ld_start_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      fail       <= fail_nxt;
      result     <= result_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    trimcode_nxt   = trimcode;
    idx_nxt        = idx;
    settle_cnt_nxt = settle_cnt;
    to_cnt_nxt     = to_cnt;
    ld_start_nxt   = 1'b0;
    done_nxt       = done;
    fail_nxt       = fail;
    result_nxt     = result;

    unique case (state)
      IDLE: begin
        if (go) begin
          done_nxt               = 1'b0;
          fail_nxt               = 1'b0;
          trimcode_nxt           = '0;
          trimcode_nxt[WIDTH-1]  = 1'b1;
          idx_nxt                = IDX_MSB;
          state_nxt              = LOAD;
        end
      end
      LOAD, FINAL_LOAD: begin
        ld_start_nxt = 1'b1;
        to_cnt_nxt   = '0;
        state_nxt    = (state == LOAD) ? WAIT_LD : FINAL_WAIT;
      end
      // A load completing on the timeout cycle still counts as success.
      WAIT_LD, FINAL_WAIT: begin
        if (ld_done) begin
          if (state == WAIT_LD) begin
            settle_cnt_nxt = '0;
            state_nxt      = SETTLE;
          end else begin
            result_nxt = trimcode;
            done_nxt   = 1'b1;
            state_nxt  = IDLE;
          end
        end else if (to_cnt == TO_LAST) begin
          fail_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (to_cnt != '1) begin
          to_cnt_nxt = to_cnt + TW'(1);
        end
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_nxt = SAMPLE;
        end else if (settle_cnt != '1) begin
          settle_cnt_nxt = settle_cnt + SW'(1);
        end
      end
      // Comparator high means the candidate overshoots, so drop the trial bit.
      SAMPLE: begin
        if (cmp_s) begin
          trimcode_nxt[idx] = 1'b0;
        end
        if (idx != '0) begin
          trimcode_nxt[idx - IW'(1)] = 1'b1;
          idx_nxt                    = idx - IW'(1);
          state_nxt                  = LOAD;
        end else begin
          state_nxt = FINAL_LOAD;
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: doc/trim_sar_ctrl.md
# trim_sar_ctrl

Successive-approximation trim search controller for the bandgap trim path. It computes a candidate WIDTH-bit trim code and hands it to the serial trim loader through a start/done handshake. After each load it waits a programmable settling time and samples the bandgap comparator, resolving one bit per iteration from MSB to LSB. The final code is reloaded and reported. The block sits between top-level test control (GO) and the serial trim loader that drives ENCLK/DOUT.

## Interface
- WIDTH, 12: trim code width.
- SETTLE_CYC, 1000: settling cycles after each load; 20 us at 50 MHz; minimum 1.
- LD_TIMEOUT, 64: maximum cycles to wait for LD_DONE; minimum 2.
- CLK50  in  1  system clock, 50 MHz; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- GO  in  1  start request; sampled only in IDLE.
- CMP  in  1  asynchronous comparator output; 1 means the trimmed voltage is above target. Synchronized internally with 2 flops.
- LD_DONE  in  1  one-cycle pulse from the loader when the serial shift completes.
- LD_START  out  1  one-cycle pulse that starts a serial load of TRIMCODE.
- TRIMCODE  out  WIDTH  code presented to the loader; stable from LD_START until LD_DONE.
- BUSY  out  1  high from the cycle after GO is accepted until entry to IDLE.
- DONE  out  1  level; search completed successfully; cleared on the next accepted GO.
- FAIL  out  1  level; loader timeout; cleared on the next accepted GO.
- RESULT  out  WIDTH  final trim code; valid while DONE is high.

## Operation
- States: IDLE, LOAD, WAIT_LD, SETTLE, SAMPLE, FINAL_LOAD, FINAL_WAIT.
- Register reset values: state=IDLE, TRIMCODE=0, LD_START=0, BUSY=0, DONE=0, FAIL=0, RESULT=0, bit index=WIDTH-1, counters=0.
- IDLE:
  - When GO=1, the block clears DONE and FAIL, sets TRIMCODE = 1<<(WIDTH-1) and idx = WIDTH-1, then goes to LOAD.
- LOAD: asserts LD_START for this cycle only, then goes to WAIT_LD.
- WAIT_LD:
  - LD_DONE=1 → SETTLE with the settle counter reset to 0.
  - If LD_TIMEOUT cycles pass without LD_DONE → FAIL=1, go to IDLE. TRIMCODE holds its value.
- SETTLE: counts SETTLE_CYC cycles, then goes to SAMPLE.
- SAMPLE: reads the synchronized CMP (cmp_s).
  - If cmp_s=1, clear TRIMCODE[idx].
  - If idx>0, set TRIMCODE[idx-1], decrement idx, go to LOAD.
  - If idx=0, go to FINAL_LOAD.
- FINAL_LOAD: LD_START pulse, then FINAL_WAIT.
- FINAL_WAIT:
  - LD_DONE → RESULT=TRIMCODE, DONE=1, go to IDLE.
  - Timeout behaves as in WAIT_LD.
- The result is the largest code for which CMP reads 0, assuming a monotonic trim.
- GO while not in IDLE is ignored.
- LD_DONE outside WAIT_LD/FINAL_WAIT is ignored.
- LD_DONE arriving on the same cycle the timeout would expire counts as success.
- RST at any time, including mid-load, forces all registers to reset values on the next edge. The loader is not notified.

## Timing
- GO accepted at edge 0 → LD_START high in the cycle after edge 1.
- Each bit iteration takes 1 (LOAD) + k (loader latency to LD_DONE, k ≥ 1) + SETTLE_CYC + 1 (SAMPLE) cycles.
- Total search time: WIDTH iterations, plus 1 + k for the final load.
- DONE and RESULT update on the same edge, one cycle after the final LD_DONE.
- The CMP path has 2 cycles of synchronizer latency. The settle period covers it whenever SETTLE_CYC ≥ 2.
- Counters are sized with $clog2 of SETTLE_CYC and LD_TIMEOUT, and saturate rather than wrap.

## Structure
- Package trim_pkg holds:
  - the state enum
  - the default trim width of 12
  - the default SETTLE_CYC and LD_TIMEOUT constants
- Sub-module trim_cmp_sync: 2-flop synchronizer for CMP, reset to 0.
- No other hierarchy; the FSM, bit index and counters live in trim_sar_ctrl.

## Test plan
- Bench setup: SETTLE_CYC=4, LD_TIMEOUT=16. The loader model pulses LD_DONE 13 cycles after LD_START. The comparator model drives CMP = (TRIMCODE > target).
- target=0x5A3, GO pulse → exactly 13 LD_START pulses, RESULT=0x5A3, DONE=1, FAIL=0. The TRIMCODE sequence starts 0x800, 0x400, 0x600, 0x500, ...
- target=0xFFF → RESULT=0xFFF. target=0x000 → RESULT=0x000. BUSY is low again on the cycle after DONE rises.
- Loader never returns LD_DONE → FAIL=1 exactly 16 cycles after the first LD_START, DONE=0, state returns to IDLE. A new GO clears FAIL.
- RST asserted during the SETTLE of bit 7 → on the next edge all outputs are 0 and state is IDLE. A following GO restarts from 0x800.
- GO held high continuously through a search → no restart mid-search. A new search begins only after the return to IDLE. A spurious LD_DONE during SETTLE does not change the cycle count or RESULT.
